tri_nor_selftest_ctrl: RTL
==========================

TRI_NOR_SELFTEST_CTRL -- requirements
Module: tri_nor_selftest_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter SETTLE_CYCLES, default 1: number of wait cycles between driving a vector and sampling outputs. Legal range is 1..15.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  level-sampled request to run one full self-test.
REQ-006 abort  input  1  terminates a running test.
REQ-007 a_out  output  3  bit i drives gate i+1 input A.
REQ-008 b_out  output  3  bit i drives gate i+1 input B.
REQ-009 c_out  output  3  bit i drives gate i+1 input C.
REQ-010 y_in  input  3  bit i is gate i+1 output Y.
REQ-011 busy  output  1  high while a test is running.
REQ-012 done  output  1  one-cycle pulse when a test completes without abort.
REQ-013 pass  output  1  set when the last completed test had zero mismatches.
REQ-014 err_cnt  output  5  number of failing vector checks in the current or last test.
REQ-015 err_gate  output  2  gate index (0..2) of the first failing check.
REQ-016 err_vec  output  3  {A,B,C} vector of the first failing check.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, APPLY, SETTLE, CHECK and DONE.
REQ-018 IDLE->APPLY SHALL occur when start=1 and abort=0; start SHALL be ignored in every other state.
REQ-019 The test SHALL walk gate g = 0,1,2 (outer loop) and vector v = 0..7 (inner loop), with v = {A,B,C} and A as the MSB.
REQ-020 APPLY (1 cycle) SHALL register the outputs: gate g inputs = v, all other gates' inputs = 000.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles; a cycle counter SHALL reload on every entry.
REQ-022 CHECK (1 cycle) SHALL compare y_in against the expected value: y_in[g] = NOR(v), and y_in[other] = 1.
REQ-023 A mismatch on any bit SHALL increment err_cnt by one per vector check; err_cnt SHALL saturate at 31.
REQ-024 err_gate and err_vec SHALL capture only the first mismatch of a test and then hold.
REQ-025 CHECK->APPLY SHALL advance v; the wrap from v=7 SHALL advance g; CHECK at g=2, v=7 SHALL go to DONE.
REQ-026 DONE (1 cycle) SHALL assert done, load pass = (err_cnt==0), and return to IDLE.
REQ-027 Latency SHALL be 24*(2+SETTLE_CYCLES) cycles from the IDLE cycle sampling start to the first APPLY of DONE; done is asserted on the following cycle.
REQ-028 busy SHALL be high in APPLY, SETTLE and CHECK, and low in IDLE and DONE.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge, force a/b/c_out to 0, suppress done, and leave pass unchanged.
REQ-030 When start and abort are high simultaneously, abort SHALL win.
REQ-031 A new start SHALL clear err_cnt, err_gate and err_vec in the IDLE->APPLY transition; pass SHALL hold until the next DONE.

Reset
REQ-032 rst_n low SHALL force state=IDLE, g=0, v=0, a/b/c_out=000, busy=0, done=0, pass=0, err_cnt=0, err_gate=0 and err_vec=0, immediately and without a clock.
REQ-033 Reset mid-test SHALL discard all progress; the first start after release SHALL begin at g=0, v=0.

Structure
REQ-034 Package tri_nor_test_pkg SHALL hold the state enum, NUM_GATES=3, NUM_VEC=8 and the width constants for g, v and err_cnt.
REQ-035 Sub-module tri_nor_vec_gen SHALL contain the g/v counters with wrap and last-vector flag; the FSM, compare and error logic SHALL remain in the top module.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Ideal gates, SETTLE_CYCLES=1, start pulse -> busy for 72 cycles, done pulse at cycle 73, pass=1, err_cnt=0.
REQ-038 y_in[1] stuck at 1 -> 7 failures (gate 1, v=1..7), err_gate=1, err_vec=001, pass=0, err_cnt=7.
REQ-039 abort asserted during gate 1, v=4 -> IDLE on the next edge, outputs 000, no done, pass unchanged; a following start completes normally with pass=1.
REQ-040 rst_n asserted mid-SETTLE -> all outputs zero asynchronously; a restart from g=0, v=0 passes.
REQ-041 SETTLE_CYCLES=3 with the 74LS27 gate model at Delay=0 -> done arrives 120 cycles after start is sampled (on the 121st cycle), pass=1.
REQ-042 start held high through DONE -> exactly one additional test begins from IDLE; start=1 together with abort=1 in IDLE -> stays IDLE.

Source files
------------

// File: rtl/tri_nor_selftest_ctrl_pkg.sv
// Shared types and constants for the triple 3-input NOR gate self-test controller.
package tri_nor_test_pkg;

  // Device under test: three 3-input NOR gates, each exercised with all 8 input vectors.
  localparam int NUM_GATES = 3;
  localparam int NUM_VEC   = 8;

  // Counter and status widths.
  localparam int G_W     = 2;  // gate index 0..2
  localparam int V_W     = 3;  // vector {A,B,C} 0..7
  localparam int ERR_W   = 5;  // mismatch count, saturating
  localparam int CNT_W   = 4;  // settle counter, holds up to 15
  localparam int STATE_W = 3;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // One-hot lane select for gate g.
  function automatic logic [NUM_GATES-1:0] lane_mask(input logic [G_W-1:0] g);
    return {{(NUM_GATES-1){1'b0}}, 1'b1} << g;
  endfunction

  // Fault-free Y pattern while gate g sees vector v and the other gates see 000:
  // the gate under test gives NOR(v), the idle gates give 1.
  function automatic logic [NUM_GATES-1:0] expected_y(input logic [G_W-1:0] g,
                                                      input logic [V_W-1:0] v);
    return (|v) ? ~lane_mask(g) : {NUM_GATES{1'b1}};
  endfunction

endpackage

// File: rtl/tri_nor_selftest_ctrl_vec_gen.sv
// Gate/vector walker: v counts 0..7 inside g counting 0..2, with a last-vector flag.
module tri_nor_vec_gen
  import tri_nor_test_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,   // park both counters at zero
  input  logic           adv_i,   // step to the next (g, v) pair
  output logic [G_W-1:0] g_o,
  output logic [V_W-1:0] v_o,
  output logic           last_o   // g == last gate and v == last vector
);

  logic [G_W-1:0] g_q, g_d;
  logic [V_W-1:0] v_q, v_d;
  logic           v_wrap;
  logic           g_wrap;

  assign v_wrap = (v_q == V_W'(NUM_VEC - 1));
  assign g_wrap = (g_q == G_W'(NUM_GATES - 1));

  // Next counter values: clear has priority, v is the inner loop, g advances on v wrap.
  always_comb begin
    g_d = g_q;
    v_d = v_q;
    if (clr_i) begin
      g_d = '0;
      v_d = '0;
    end else if (adv_i) begin
      if (v_wrap) begin
        v_d = '0;
        g_d = g_wrap ? '0 : g_q + G_W'(1);
      end else begin
        v_d = v_q + V_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q <= '0;
      v_q <= '0;
    end else begin
      g_q <= g_d;
      v_q <= v_d;
    end
  end

  assign g_o    = g_q;
  assign v_o    = v_q;
  assign last_o = g_wrap && v_wrap;

endmodule

// File: rtl/tri_nor_selftest_ctrl.sv
// Self-test controller for a triple 3-input NOR package (74LS27 style).
// Walks every gate through all 8 input vectors, waits SETTLE_CYCLES after each
// drive, compares Y against NOR, and records error count plus first failure.
//
// Handshake: start is a level request sampled only in IDLE; abort is a level
// request honoured in every non-IDLE state and beats start; done is a one-cycle
// pulse coincident with the DONE state, and pass/err_* are valid from that cycle.
//
// SETTLE_CYCLES legal range is 1..15.
module tri_nor_selftest_ctrl
  import tri_nor_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [NUM_GATES-1:0] a_out,
  output logic [NUM_GATES-1:0] b_out,
  output logic [NUM_GATES-1:0] c_out,
  input  logic [NUM_GATES-1:0] y_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [G_W-1:0]       err_gate,
  output logic [V_W-1:0]       err_vec,
  output logic [STATE_W-1:0]   dbg_state
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_GATES-1:0] a_q, a_d;
  logic [NUM_GATES-1:0] b_q, b_d;
  logic [NUM_GATES-1:0] c_q, c_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic [G_W-1:0]       err_gate_q, err_gate_d;
  logic [V_W-1:0]       err_vec_q, err_vec_d;

  logic [G_W-1:0] g_w;
  logic [V_W-1:0] v_w;
  logic           last_w;
  logic           vec_clr;
  logic           vec_adv;
  logic           do_check;
  logic           mismatch;
  logic [NUM_GATES-1:0] lane;

  // Counters sit at (0,0) whenever idle, so any restart begins from the first vector.
  assign vec_clr = (state_q == ST_IDLE);
  assign vec_adv = (state_q == ST_CHECK) && (state_d == ST_APPLY);

  tri_nor_vec_gen u_vec_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (vec_clr),
    .adv_i  (vec_adv),
    .g_o    (g_w),
    .v_o    (v_w),
    .last_o (last_w)
  );

  // A check that coincides with abort is discarded along with the test.
  assign do_check = (state_q == ST_CHECK) && !abort;
  assign mismatch = (y_in != expected_y(g_w, v_w));
  assign lane     = lane_mask(g_w);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort returns to IDLE from anywhere but IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start && !abort) state_d = ST_APPLY;
      ST_APPLY:  state_d = abort ? ST_IDLE : ST_SETTLE;
      ST_SETTLE: begin
        if (abort)            state_d = ST_IDLE;
        else if (cnt_q == '0) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)       state_d = ST_IDLE;
        else if (last_w) state_d = ST_DONE;
        else             state_d = ST_APPLY;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Settle counter: reloaded while in APPLY so every SETTLE visit starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_APPLY) begin
      cnt_d = CNT_W'(SETTLE_CYCLES - 1);
    end else if ((state_q == ST_SETTLE) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Output/status next values, all taken into registers below.
  always_comb begin
    busy_d     = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d     = (state_d == ST_DONE);
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    err_cnt_d  = err_cnt_q;
    err_gate_d = err_gate_q;
    err_vec_d  = err_vec_q;
    pass_d     = pass_q;

    // Drive the current vector on gate g only; SETTLE then sees it stable.
    if (state_q == ST_APPLY) begin
      a_d = v_w[2] ? lane : '0;
      b_d = v_w[1] ? lane : '0;
      c_d = v_w[0] ? lane : '0;
    end
    // Gate inputs are released whenever the test is not running.
    if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      a_d = '0;
      b_d = '0;
      c_d = '0;
    end

    // A fresh test forgets the previous error record; pass is kept until DONE.
    if ((state_q == ST_IDLE) && (state_d == ST_APPLY)) begin
      err_cnt_d  = '0;
      err_gate_d = '0;
      err_vec_d  = '0;
    end
    // Count is still zero exactly on the first mismatch, so it doubles as the capture flag.
    if (do_check && mismatch) begin
      if (err_cnt_q == '0) begin
        err_gate_d = g_w;
        err_vec_d  = v_w;
      end
      if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end

    // Verdict uses the count including the final check made on the way into DONE.
    if (state_d == ST_DONE) begin
      pass_d = (err_cnt_d == '0);
    end
  end

  // Output and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_gate_q <= '0;
      err_vec_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_gate_q <= err_gate_d;
      err_vec_q  <= err_vec_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign c_out     = c_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign err_gate  = err_gate_q;
  assign err_vec   = err_vec_q;
  assign dbg_state = state_q;

endmodule
